// File: rtl/spi_txn_arbiter.sv
// Round-robin scheduler sharing one SPI master among N_REQ requesters.
// Drives the master's load/data/select/mode inputs and returns the received byte.
module spi_txn_arbiter #(
    parameter int N_REQ      = 3,
    parameter int TIMEOUT    = 255,
    parameter int GAP_CYCLES = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_REQ-1:0]   req,
    input  logic [8*N_REQ-1:0] req_data,
    input  logic [2*N_REQ-1:0] req_sel,
    input  logic               cfg_we,
    input  logic [1:0]         cfg_addr,
    input  logic [1:0]         cfg_mode,
    input  logic               check_end,
    input  logic [7:0]         master_data,
    output logic               mas_load,
    output logic [7:0]         init_master,
    output logic [1:0]         select,
    output logic               CPOL,
    output logic               CPHA,
    output logic [N_REQ-1:0]   ack,
    output logic [7:0]         rsp_data,
    output logic               rsp_err,
    output logic               busy
);
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [2:0] {IDLE, LOAD, WAIT, RESP, GAP} state_t;

    state_t           state;
    logic [1:0]       mode_reg [0:3];
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] winner;
    logic [15:0]      timeout_cnt;
    logic [3:0]       gap_cnt;
    logic             check_end_q;

    logic             pick_valid;
    logic [IDX_W-1:0] pick;
    logic [IDX_W:0]   scan_sum;
    logic [IDX_W-1:0] scan_idx;
    logic [7:0]       pick_data;
    logic [1:0]       pick_sel;
    logic             check_end_rise;

    // First requester at or above rr_ptr, wrapping around.
    always_comb begin
        pick_valid = 1'b0;
        pick       = '0;
        scan_sum   = '0;
        scan_idx   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            scan_sum = {1'b0, rr_ptr} + (IDX_W+1)'(i);
            if (scan_sum >= (IDX_W+1)'(N_REQ))
                scan_sum = scan_sum - (IDX_W+1)'(N_REQ);
            scan_idx = scan_sum[IDX_W-1:0];
            if (!pick_valid && req[scan_idx]) begin
                pick_valid = 1'b1;
                pick       = scan_idx;
            end
        end
    end

    assign pick_data      = req_data[8*pick +: 8];
    assign pick_sel       = req_sel[2*pick +: 2];
    assign check_end_rise = check_end && !check_end_q;
    assign busy           = (state != IDLE);

    // Entry 3 is never written; an invalid target never reaches LOAD.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) mode_reg[i] <= 2'b00;
        end else if (cfg_we && cfg_addr != 2'd3) begin
            mode_reg[cfg_addr] <= cfg_mode;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            winner      <= '0;
            timeout_cnt <= '0;
            gap_cnt     <= '0;
            check_end_q <= 1'b0;
            mas_load    <= 1'b0;
            init_master <= 8'h00;
            select      <= 2'd0;
            CPOL        <= 1'b0;
            CPHA        <= 1'b0;
            ack         <= '0;
            rsp_data    <= 8'h00;
            rsp_err     <= 1'b0;
        end else begin
            check_end_q <= check_end;
            mas_load    <= 1'b0;
            ack         <= '0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        winner <= pick;
                        if (pick_sel == 2'd3) begin
                            ack      <= N_REQ'(1) << pick;
                            rsp_data <= 8'h00;
                            rsp_err  <= 1'b1;
                            state    <= RESP;
                        end else begin
                            // Bus outputs are registered so they appear together with the load pulse.
                            mas_load     <= 1'b1;
                            init_master  <= pick_data;
                            select       <= pick_sel;
                            {CPOL, CPHA} <= mode_reg[pick_sel];
                            state        <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    timeout_cnt <= '0;
                    state       <= WAIT;
                end
                WAIT: begin
                    if (check_end_rise) begin
                        ack      <= N_REQ'(1) << winner;
                        rsp_data <= master_data;
                        rsp_err  <= 1'b0;
                        state    <= RESP;
                    end else if (timeout_cnt == 16'(TIMEOUT-1)) begin
                        ack      <= N_REQ'(1) << winner;
                        rsp_data <= 8'h00;
                        rsp_err  <= 1'b1;
                        state    <= RESP;
                    end else begin
                        timeout_cnt <= timeout_cnt + 16'd1;
                    end
                end
                RESP: begin
                    rr_ptr  <= (winner == IDX_W'(N_REQ-1)) ? '0 : winner + 1'b1;
                    gap_cnt <= '0;
                    state   <= (GAP_CYCLES == 0) ? IDLE : GAP;
                end
                GAP: begin
                    if (gap_cnt == 4'(GAP_CYCLES-1)) state <= IDLE;
                    else gap_cnt <= gap_cnt + 4'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Directed bench for spi_txn_arbiter: round-robin, single transfer, invalid
// target, timeouts, config race and asynchronous reset.
module tb_spi_txn_arbiter;
    localparam int N = 3;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] req;
    logic [8*N-1:0] req_data;
    logic [2*N-1:0] req_sel;
    logic         cfg_we;
    logic [1:0]   cfg_addr;
    logic [1:0]   cfg_mode;
    logic         check_end;
    logic [7:0]   master_data;
    logic         mas_load;
    logic [7:0]   init_master;
    logic [1:0]   select;
    logic         CPOL;
    logic         CPHA;
    logic [N-1:0] ack;
    logic [7:0]   rsp_data;
    logic         rsp_err;
    logic         busy;

    int n_checks = 0;
    int n_fail   = 0;

    spi_txn_arbiter #(.N_REQ(N), .TIMEOUT(8), .GAP_CYCLES(2)) dut (
        .clk(clk), .reset(reset), .req(req), .req_data(req_data), .req_sel(req_sel),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_mode(cfg_mode),
        .check_end(check_end), .master_data(master_data),
        .mas_load(mas_load), .init_master(init_master), .select(select),
        .CPOL(CPOL), .CPHA(CPHA), .ack(ack), .rsp_data(rsp_data),
        .rsp_err(rsp_err), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed no end of test, expected finish before 100000");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_load(input string tag);
        int k = 0;
        while (mas_load !== 1'b1 && k < 20) begin tick(); k++; end
        check({tag, "_load"}, mas_load, 1);
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while (busy !== 1'b0 && k < 20) begin tick(); k++; end
        check({tag, "_idle"}, busy, 0);
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [1:0] m);
        cfg_we = 1'b1; cfg_addr = a; cfg_mode = m;
        tick();
        cfg_we = 1'b0;
    endtask

    // Waits for the load, produces one check_end edge, leaves us in the RESP cycle.
    task automatic serve(input string tag, input logic [N-1:0] exp_ack,
                         input logic [7:0] exp_init, input logic [7:0] md);
        wait_load(tag);
        check({tag, "_init"}, init_master, exp_init);
        tick();
        master_data = md; check_end = 1'b1;
        tick();
        check({tag, "_ack"}, ack, exp_ack);
        check({tag, "_rsp"}, rsp_data, md);
        check({tag, "_err"}, rsp_err, 0);
        check_end = 1'b0;
    endtask

    initial begin
        reset = 1'b1; req = '0; req_data = '0; req_sel = '0;
        cfg_we = 1'b0; cfg_addr = 2'd0; cfg_mode = 2'd0;
        check_end = 1'b0; master_data = 8'h00;
        tick(); tick();
        check("rst_outs", {mas_load, init_master, select, CPOL, CPHA, ack, rsp_data, rsp_err, busy}, 0);
        reset = 1'b0;
        tick();

        // Round-robin with all three requesting continuously.
        req_data = {8'h33, 8'h22, 8'h11}; req_sel = '0; req = 3'b111;
        serve("rr0", 3'b001, 8'h11, 8'hC0);
        serve("rr1", 3'b010, 8'h22, 8'hC1);
        serve("rr2", 3'b100, 8'h33, 8'hC2);
        serve("rr3", 3'b001, 8'h11, 8'hC3);
        req = 3'b101;
        serve("rr_ptr1", 3'b100, 8'h33, 8'hC4);
        req = '0;
        wait_idle("rr");

        // Single request with exact cycle timing.
        cfg_write(2'd1, 2'b10);
        cfg_write(2'd2, 2'b11);
        req_data[7:0] = 8'hA5; req_sel[1:0] = 2'd1; req = 3'b001;
        tick();
        check("t1_load", mas_load, 1);
        check("t1_init", init_master, 8'hA5);
        check("t1_sel", select, 2'd1);
        check("t1_mode", {CPOL, CPHA}, 2'b10);
        check("t1_busy", busy, 1);
        tick();
        check("t1_pulse", mas_load, 0);
        master_data = 8'h3C; check_end = 1'b1;
        tick();
        check("t1_ack", ack, 3'b001);
        check("t1_rsp", rsp_data, 8'h3C);
        check("t1_err", rsp_err, 0);
        req = '0; check_end = 1'b0;
        tick();
        check("t1_ack_once", ack, 0);
        check("t1_gap1", busy, 1);
        tick();
        check("t1_gap2", busy, 1);
        tick();
        check("t1_gap_end", busy, 0);

        // Invalid target on requester 1.
        req_sel[3:2] = 2'd3; req = 3'b010;
        tick();
        check("inv_ack", ack, 3'b010);
        check("inv_err", rsp_err, 1);
        check("inv_rsp", rsp_data, 0);
        check("inv_noload", mas_load, 0);
        check("inv_sel_hold", select, 2'd1);
        req = '0;
        tick();
        check("inv_ack_once", ack, 0);
        check("inv_gap", busy, 1);
        wait_idle("inv");

        // Timeout with check_end low, requester 2 to slave 3.
        req_data[23:16] = 8'h5A; req_sel[5:4] = 2'd2; req = 3'b100;
        tick();
        check("to_load", mas_load, 1);
        check("to_sel", select, 2'd2);
        check("to_mode", {CPOL, CPHA}, 2'b11);
        repeat (8) tick();
        check("to_early", ack, 0);
        tick();
        check("to_ack", ack, 3'b100);
        check("to_err", rsp_err, 1);
        check("to_rsp", rsp_data, 0);
        req = '0;
        wait_idle("to");

        // check_end stuck high across the whole transfer must also time out.
        check_end = 1'b1;
        tick();
        req_data[7:0] = 8'hE7; req_sel[1:0] = 2'd0; req = 3'b001;
        tick();
        check("stk_load", mas_load, 1);
        repeat (8) tick();
        check("stk_early", ack, 0);
        tick();
        check("stk_ack", ack, 3'b001);
        check("stk_err", rsp_err, 1);
        req = '0; check_end = 1'b0;
        wait_idle("stk");

        // Config write to slave 0 while its transfer is in WAIT.
        req_data[15:8] = 8'h77; req_sel[3:2] = 2'd0; req = 3'b010;
        tick();
        check("race_load", mas_load, 1);
        check("race_mode0", {CPOL, CPHA}, 2'b00);
        tick();
        cfg_we = 1'b1; cfg_addr = 2'd0; cfg_mode = 2'b01;
        tick();
        cfg_we = 1'b0;
        check("race_hold", {CPOL, CPHA}, 2'b00);
        master_data = 8'h81; check_end = 1'b1;
        tick();
        check("race_ack", ack, 3'b010);
        check("race_rsp", rsp_data, 8'h81);
        check("race_hold2", {CPOL, CPHA}, 2'b00);
        check_end = 1'b0; req = '0;
        wait_idle("race");
        cfg_write(2'd3, 2'b11);
        req_data[7:0] = 8'h42; req = 3'b001;
        serve("race_next", 3'b001, 8'h42, 8'h99);
        check("race_new_mode", {CPOL, CPHA}, 2'b01);
        req = '0;
        wait_idle("race_next");

        // Reset in WAIT: outputs clear at once, pointer and modes return to 0.
        req = 3'b010;
        wait_load("rst_mid");
        req = 3'b101; req_sel[5:4] = 2'd2;
        tick();
        #2 reset = 1'b1;
        #1;
        check("rst_async", {mas_load, init_master, select, CPOL, CPHA, ack, busy}, 0);
        tick();
        check("rst_no_ack", ack, 0);
        reset = 1'b0;
        tick();
        check("rst_regrant", mas_load, 1);
        check("rst_from0", init_master, 8'h42);
        check("rst_mode", {CPOL, CPHA}, 2'b00);
        tick();
        master_data = 8'h6D; check_end = 1'b1;
        tick();
        check("rst_ack", ack, 3'b001);
        check("rst_rsp", rsp_data, 8'h6D);
        req = '0; check_end = 1'b0;
        wait_idle("rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/spi_txn_arbiter.md
# spi_txn_arbiter

Transaction scheduler that shares the single SPI master among several on-chip requesters. It arbitrates round-robin, drives the master's load, data, slave-select and clock-mode inputs, and waits for the master's end-of-transfer flag. It then returns the received byte to the winning requester. It sits directly in front of the master/three-slave SPI integration and is the only block that drives the master's control inputs.

## Interface
Parameters:
- N_REQ, 3, number of requesters (2..8)
- TIMEOUT, 255, max cycles in WAIT before error completion (1..65535)
- GAP_CYCLES, 2, idle cycles forced between transactions (0..15)

Ports:
- clk  in  1  system clock; all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- req  in  N_REQ  per-requester request, level; held until matching ack
- req_data  in  8*N_REQ  byte to send, requester i at [8i+7:8i]; stable while req[i]=1
- req_sel  in  2*N_REQ  target slave, requester i at [2i+1:2i]; 0/1/2 = slave 1/2/3, 3 = invalid
- cfg_we  in  1  write per-slave mode register
- cfg_addr  in  2  slave index 0..2 for cfg write; 3 ignored
- cfg_mode  in  2  {CPOL,CPHA} written on cfg_we
- check_end  in  1  master end-of-transfer flag
- master_data  in  8  master receive register
- mas_load  out  1  one-cycle load pulse to master
- init_master  out  8  byte presented to master
- select  out  2  slave select to master
- CPOL  out  1  clock polarity to master and slaves
- CPHA  out  1  clock phase to master and slaves
- ack  out  N_REQ  one-hot, one-cycle completion pulse
- rsp_data  out  8  received byte, valid while ack≠0
- rsp_err  out  1  error flag, valid while ack≠0
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, LOAD, WAIT, RESP, GAP.
- IDLE: if req≠0, grant the first set bit searching upward from rr_ptr with wraparound. Latch winner index, data and target. If target=3, go to RESP with err=1 and skip the bus. Otherwise go to LOAD.
- LOAD: mas_load=1 for exactly one cycle. init_master = latched data. select = target. {CPOL,CPHA} = mode_reg[target], latched here. Then go to WAIT.
- WAIT: detect a check_end rising edge (check_end=1 with previous-cycle value 0; previous-value register resets to 0).
  - On the edge, capture master_data, err=0, and go to RESP.
  - If timeout_cnt reaches TIMEOUT-1 with no edge, set rsp_data=0, err=1, and go to RESP.
- RESP: ack[winner]=1, rsp_data and rsp_err driven. rr_ptr ← (winner+1) mod N_REQ. Go to GAP, or to IDLE if GAP_CYCLES=0.
- GAP: count GAP_CYCLES cycles, then go to IDLE.
- init_master, select, CPOL and CPHA hold their latched values from LOAD until the next LOAD. They are not forced to 0 between transactions.
- Config writes are accepted in any state. They affect only transactions whose LOAD occurs after the write. A write to cfg_addr=3 has no effect.
- A requester dropping req before its ack still completes its already-granted transaction.
- A new req arriving during a transaction waits for IDLE. A winner's req still high after its ack is re-arbitrated fairly, with lowest priority.

## Timing
- Reset values: all outputs 0; mode_reg[0..2]=00; rr_ptr=0; state=IDLE; counters 0.
- Reset asserted mid-transaction aborts immediately: no ack, and mas_load drops asynchronously.
- Request seen in IDLE at cycle t: mas_load=1 at t+1, WAIT from t+2.
- Edge seen in WAIT at cycle e: ack=1 at e+1. GAP occupies e+2..e+1+GAP_CYCLES. Next grant is possible at e+2+GAP_CYCLES.
- Invalid target seen at t: ack with err at t+1; no mas_load.
- Timeout: WAIT lasts exactly TIMEOUT cycles, then ack with err=1.
- ack is never asserted for more than one cycle or on more than one bit.

## Test plan
- Single request: req=001, data 0xA5, sel 1, cfg[1]=10. Expect mas_load pulse at t+1 with init_master=A5, select=1, CPOL=1, CPHA=0. Model check_end edge with master_data=0x3C. Expect ack=001, rsp_data=3C, err=0 one cycle later.
- Round-robin: req=111 held continuously. Expect grant order 0,1,2,0. With rr_ptr=1 and req=101, expect requester 2 granted first.
- Invalid target: sel=3 on requester 1. Expect ack=010 with err=1 at t+1, no mas_load, then GAP.
- Timeout: TIMEOUT=8 and check_end held low. Expect ack with err=1 and rsp_data=00 exactly 8 WAIT cycles after LOAD. Check_end stuck high from a prior transfer must also time out (no edge).
- Config race: cfg_we to slave 0 during WAIT of a slave-0 transfer. CPOL/CPHA stay unchanged until the next LOAD, then take the new value.
- Reset mid-WAIT: assert reset. All outputs go to 0 immediately. After release, a pending req is granted starting from requester 0.
